// File: rtl/aes128_key_schedule_ctrl.sv
// AES-128 key-expansion controller: one combinational round-key generator is
// iterated ten times and every round key lands in a store behind a registered read port.
module aes128_key_schedule_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [127:0] i_key,
    output logic         o_busy,
    output logic         o_keys_valid,
    input  logic         i_rd_en,
    input  logic [3:0]   i_rd_round,
    output logic         o_rd_valid,
    output logic [127:0] o_rd_key,
    output logic         o_rd_err
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [3:0]   rc_reg;
    logic [3:0]   rc_next;
    logic [3:0]   wr_count_reg;
    logic [3:0]   wr_count_next;
    logic [127:0] work_reg;

    logic         accept;
    logic         expanding;
    logic         store_wr_en;
    logic [3:0]   store_wr_addr;
    logic [127:0] store_wr_data;
    logic [127:0] key_store [0:NUM_ROUNDS];

    logic [3:0]   rd_addr;
    logic         rd_ok;
    logic         rd_valid_reg;
    logic         rd_hit_reg;
    logic [127:0] rd_data_reg;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp_word;
    logic [127:0] gen_key;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic for the S-box
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] r1, r2, r3, r4;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        r1 = {inv[6:0], inv[7]};
        r2 = {inv[5:0], inv[7:6]};
        r3 = {inv[4:0], inv[7:5]};
        r4 = {inv[3:0], inv[7:4]};
        return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] val;
        case (rnd)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // ------------------------------------------------------------------
    // Single-round key generator fed from the working register
    // ------------------------------------------------------------------
    assign w0 = work_reg[127:96];
    assign w1 = work_reg[95:64];
    assign w2 = work_reg[63:32];
    assign w3 = work_reg[31:0];

    assign rot_word = {w3[23:0], w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    assign temp_word = sub_word ^ {rcon(rc_reg), 24'h000000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_next_words
            if (gi == 0) begin : g_first
                assign gen_key[127:96] = w0 ^ temp_word;
            end else begin : g_chain
                // Each new word is the previous new word XOR the old word in that position.
                assign gen_key[127-gi*32 -: 32] = gen_key[127-(gi-1)*32 -: 32] ^ work_reg[127-gi*32 -: 32];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            rc_reg       <= 4'd0;
            wr_count_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            rc_reg       <= rc_next;
            wr_count_reg <= wr_count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_READY: begin
                if (i_key_valid) begin
                    state_next = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (rc_reg == LAST_ROUND) begin
                    state_next = ST_READY;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_key_ready  = 1'b0;
        o_busy       = 1'b0;
        o_keys_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                o_key_ready = 1'b1;
            end
            ST_EXPAND: begin
                o_busy = 1'b1;
            end
            ST_READY: begin
                o_key_ready  = 1'b1;
                o_keys_valid = 1'b1;
            end
            default: begin
                o_key_ready = 1'b0;
            end
        endcase
    end

    assign accept    = i_key_valid && o_key_ready;
    assign expanding = (state_reg == ST_EXPAND);

    always_comb begin
        rc_next       = rc_reg;
        wr_count_next = wr_count_reg;
        if (accept) begin
            rc_next       = 4'd1;
            wr_count_next = 4'd1;
        end else if (expanding) begin
            rc_next       = rc_reg + 4'd1;
            wr_count_next = rc_reg + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            work_reg <= i_key;
        end else if (expanding) begin
            work_reg <= gen_key;
        end
    end

    // ------------------------------------------------------------------
    // Key store: one write per cycle, registered read
    // ------------------------------------------------------------------
    assign store_wr_en   = accept || expanding;
    assign store_wr_addr = accept ? 4'd0 : rc_reg;
    assign store_wr_data = accept ? i_key : gen_key;

    always_ff @(posedge i_clk) begin
        if (store_wr_en) begin
            key_store[store_wr_addr] <= store_wr_data;
        end
    end

    // Availability uses the pre-edge write count, so a slot written this edge reads as missing.
    assign rd_ok   = (i_rd_round <= LAST_ROUND) && (i_rd_round < wr_count_reg);
    assign rd_addr = (i_rd_round > LAST_ROUND) ? 4'd0 : i_rd_round;

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            rd_data_reg <= key_store[rd_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_hit_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= i_rd_en;
            if (i_rd_en) begin
                rd_hit_reg <= rd_ok;
            end
        end
    end

    // The hit flag masks the uninitialised store data after reset or on a rejected read.
    assign o_rd_valid = rd_valid_reg;
    assign o_rd_err   = rd_valid_reg && !rd_hit_reg;
    assign o_rd_key   = rd_hit_reg ? rd_data_reg : 128'h0;

endmodule

// File: doc/aes128_key_schedule_ctrl.md
Name: aes128_key_schedule_ctrl

Overview:
Sequential AES-128 key-expansion controller that sits directly upstream of the cipher round datapath. It accepts a 128-bit cipher key through a valid/ready handshake and runs one Key_Generator instance (combinational single-round expansion) for 10 iterations. It stores all 11 round keys in an internal key store and serves them through a registered read port indexed by round number.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; the store holds NUM_ROUNDS+1 keys. Only the value 10 is supported.

Ports:
i_clk  input  1  clock; all logic is rising-edge triggered
i_rst_n  input  1  asynchronous, active-low reset
i_key_valid  input  1  cipher key present on i_key
o_key_ready  output  1  controller can accept a key
i_key  input  128  cipher key; [127:120]=word0 byte0 … [7:0]=word3 byte3
o_busy  output  1  expansion in progress
o_keys_valid  output  1  all 11 round keys stored and valid
i_rd_en  input  1  read request
i_rd_round  input  4  round index to read, 0..10
o_rd_valid  output  1  read response strobe, one cycle after i_rd_en
o_rd_key  output  128  round key read; same byte order as i_key
o_rd_err  output  1  qualifies o_rd_valid; the requested slot is not available

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state is IDLE and wr_count is 0.
  - o_busy, o_keys_valid, o_rd_valid, o_rd_err and o_rd_key are all 0.
  - o_key_ready is 1.
  - Key-store contents are not reset. Read gating makes them unobservable.
- States:
  - IDLE: no keys held.
  - EXPAND: expansion running.
  - READY: 11 keys held.
- Outputs per state:
  - o_key_ready = 1 in IDLE and READY, 0 in EXPAND.
  - o_busy = 1 in EXPAND only.
  - o_keys_valid = 1 in READY only.
- Accept: when i_key_valid && o_key_ready at edge T:
  - slot0 <= i_key and working register <= i_key.
  - round counter rc <= 1, wr_count <= 1, state <= EXPAND.
  - In READY this discards the old key set. o_keys_valid falls after edge T.
- EXPAND, every cycle:
  - Key_Generator input words are taken from the working register.
  - Key_Generator round number = rc (1..10). Rcon(1)=0x01 … Rcon(10)=0x36.
  - At the edge: slot[rc] <= generator output, working register <= generator output, wr_count <= rc+1, rc <= rc+1.
  - When rc==10 the state goes to READY at that edge.
- Latency: slot10 is written at edge T+10. o_keys_valid and o_key_ready are high from edge T+10 onward. Total is 10 cycles after accept.
- i_key_valid during EXPAND is ignored (not back-pressured into storage), because o_key_ready=0.
- Read port (registered, 1-cycle latency):
  - i_rd_en at edge N produces o_rd_valid=1 for the cycle after edge N.
  - If i_rd_round <= 10 and i_rd_round < wr_count: o_rd_key = slot[i_rd_round] and o_rd_err = 0.
  - Otherwise: o_rd_key = 0 and o_rd_err = 1.
  - Without i_rd_en: o_rd_valid = 0 and o_rd_err = 0. o_rd_key holds its last value.
- Simultaneous events:
  - A read of a slot being written at the same edge uses the pre-edge wr_count, so it returns an error.
  - A read at the same edge as a new accept uses the old contents and old wr_count.
- Reset mid-EXPAND aborts immediately: IDLE, wr_count=0, and every read returns an error until a new key is accepted.
- Widths:
  - rc is 4 bits; wr_count is 4 bits (0..11).
  - i_rd_round values 11..15 always return an error.

Test Plan:
1. Reset, then read round 0 -> o_rd_valid=1, o_rd_err=1, o_rd_key=0; o_key_ready=1, o_keys_valid=0.
2. Key 2b7e151628aed2a6abf7158809cf4f3c accepted at T:
   - o_busy is high for edges T..T+9.
   - o_keys_valid is high after T+10.
   - Read round 1 -> a0fafe1788542cb123a339392a6c7605.
   - Read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Read round 0 -> the original key.
3. Read round 5 three cycles after accept -> o_rd_err=1. Read round 2 at the same time -> round-2 key f2c295f27a96b9435935807a7359f67f with o_rd_err=0.
4. Hold i_key_valid high with a different key during EXPAND -> it is ignored. The final round 10 still matches the FIPS-197 vector. After READY, the new key is accepted in 1 cycle and o_keys_valid drops.
5. Assert i_rst_n=0 mid-EXPAND (asynchronously, between edges):
   - Outputs clear immediately.
   - After release, a read of round 0 returns an error.
   - Re-expansion of the test key produces correct values.
6. Read i_rd_round=11 and 15 in READY -> o_rd_err=1, o_rd_key=0. Back-to-back reads of rounds 0..10 return each key on consecutive cycles.
